vecmac_stream: RTL and testbench
================================

VECMAC_STREAM -- requirements
Module: vecmac_stream

Interface
REQ-001 SHALL have parameter LANES, default 8, number of int8 lanes per beat (legal: 1, 2, 4, 8, 16).
REQ-002 SHALL have parameter ACC_W, default 32, accumulator/result width (legal: 24..48).
REQ-003 SHALL have parameter LEN_W, default 16, width of vector-length field.
REQ-004 SHALL have port clk  input  1  sole clock, rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port start  input  1  one-cycle run request, sampled in IDLE only.
REQ-007 SHALL have port cfg_len  input  LEN_W  element count, latched on accepted start.
REQ-008 SHALL have port cfg_signed  input  1  1 = signed int8 operands, 0 = unsigned; latched on accepted start.
REQ-009 SHALL have ports in_valid (input, 1) and in_ready (output, 1), operand beat handshake.
REQ-010 SHALL have ports in_a and in_b  input  8*LANES  packed operands, lane i at bits [8i+7:8i].
REQ-011 SHALL have ports out_valid (output, 1) and out_ready (input, 1), result handshake.
REQ-012 SHALL have port out_sum  output  ACC_W  dot-product result, two's complement.
REQ-013 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-014 SHALL implement FSM IDLE -> RUN -> DRAIN -> DONE -> IDLE.
REQ-015 IDLE: start=1 latches cfg, clears accumulator, computes beats = ceil(cfg_len/LANES); goes to RUN, or to DRAIN directly if cfg_len=0.
REQ-016 RUN: in_ready=1; beat transferred when in_valid&&in_ready; after final beat transfers, goes to DRAIN.
REQ-017 Final beat: lanes with index >= (cfg_len mod LANES) SHALL contribute zero when remainder is nonzero.
REQ-018 Datapath SHALL be 3 registered stages: lane products, adder-tree sum, accumulate; no bubbles or stalls.
REQ-019 DRAIN SHALL last exactly until the last transferred beat has been accumulated; out_valid SHALL assert exactly 3 cycles after the final beat transfer (2 cycles after start for cfg_len=0).
REQ-020 DONE: out_valid=1, out_sum stable; out_valid&&out_ready returns FSM to IDLE in the next cycle.
REQ-021 Products SHALL be 16-bit signed (signed mode) or 17-bit zero-extended (unsigned); tree width 17+log2(LANES); accumulation sign-extends to ACC_W.
REQ-022 start while busy SHALL be ignored; in_valid outside RUN SHALL be ignored.
REQ-023 start in same cycle as a DONE handshake SHALL be ignored (FSM is not yet IDLE).

Reset
REQ-024 rst_n low SHALL asynchronously force IDLE, in_ready=0, out_valid=0, busy=0, out_sum=0, and clear all pipeline valid bits and counters, including mid-run.
REQ-025 Deassertion SHALL be the only exit from reset; first start is honoured on the first clock edge after rst_n is high.

Configuration
REQ-026 With VECMAC_SAT_EN defined, accumulation SHALL saturate to the signed ACC_W limits and hold there; output ovf (1 bit, valid with out_valid, cleared on start) SHALL flag any saturation.
REQ-027 Without VECMAC_SAT_EN, accumulation SHALL wrap modulo 2^ACC_W and port ovf SHALL not exist.

Structure
REQ-028 Package vecmac_pkg SHALL hold the FSM state enum, product/tree width functions, and legal-LANES check constant.
REQ-029 Stages 1-2 SHALL be sub-module vecmac_lane_tree (LANES multipliers plus pipelined adder tree, with lane mask input).
REQ-030 Illegal LANES or ACC_W SHALL fail at elaboration.

Verification
REQ-031 LANES=8, unsigned, cfg_len=16, all operands 255 -> out_sum=1040400, out_valid 3 cycles after second beat.
REQ-032 LANES=8, signed, cfg_len=10, a=-128, b=127 in every lane -> out_sum=-162560 (lanes 2..7 of beat 2 masked).
REQ-033 cfg_len=0 -> out_sum=0, out_valid 2 cycles after start, no beats accepted.
REQ-034 Random in_valid gaps and out_ready held low 5 cycles -> sum equals golden model, out_sum stable until handshake, start ignored meanwhile.
REQ-035 rst_n pulsed low mid-RUN -> all outputs 0 immediately; next run with cfg_len=4, LANES=4, operands 1 -> out_sum=4.
REQ-036 VECMAC_SAT_EN, ACC_W=24, signed, cfg_len=1024, a=b=-128 -> out_sum=8388607, ovf=1; without macro -> wrapped value 16777216 mod 2^24 = 0.

Source files
------------

// File: rtl/vecmac_pkg.sv
// vecmac_pkg: shared FSM states, datapath widths and parameter legality checks
// for the vecmac_stream int8 dot-product engine.
package vecmac_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam int PROD_W = 17;

  function automatic int prod_w();
    return PROD_W;
  endfunction

  function automatic int tree_w(input int lanes);
    return PROD_W + $clog2(lanes);
  endfunction

  function automatic bit lanes_legal(input int l);
    return l == 1 || l == 2 || l == 4 || l == 8 || l == 16;
  endfunction

  function automatic bit acc_legal(input int w);
    return w >= 24 && w <= 48;
  endfunction

endpackage

// File: rtl/vecmac_lane_tree.sv
// vecmac_lane_tree: stage 1 masked lane products, stage 2 registered
// lane-sum, with valid/last tags travelling alongside the data.
module vecmac_lane_tree
  import vecmac_pkg::*;
#(
  parameter int LANES = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          valid,
  input  logic                          last,
  input  logic                          sgn,
  input  logic [LANES-1:0]              mask,
  input  logic [8*LANES-1:0]            a,
  input  logic [8*LANES-1:0]            b,
  output logic                          sum_valid,
  output logic                          sum_last,
  output logic signed [tree_w(LANES)-1:0] sum
);

  localparam int TW = tree_w(LANES);

  logic signed [PROD_W-1:0] prod_d [LANES];
  logic signed [PROD_W-1:0] prod_q [LANES];
  logic signed [TW-1:0]     sum_d;
  logic                     v1;
  logic                     l1;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [7:0]         ai;
    logic [7:0]         bi;
    logic signed [15:0] ps;
    logic [15:0]        pu;
    assign ai = a[8*i +: 8];
    assign bi = b[8*i +: 8];
    assign ps = $signed({{8{ai[7]}}, ai}) * $signed({{8{bi[7]}}, bi});
    assign pu = {8'd0, ai} * {8'd0, bi};
    assign prod_d[i] = !mask[i] ? '0 :
                       sgn      ? {ps[15], ps} :
                                  {1'b0, pu};
  end

  always_comb begin
    sum_d = '0;
    for (int i = 0; i < LANES; i++)
      sum_d = sum_d + TW'(prod_q[i]);
  end

  always_ff @(posedge clk) begin
    prod_q <= prod_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1        <= 1'b0;
      l1        <= 1'b0;
      sum_valid <= 1'b0;
      sum_last  <= 1'b0;
      sum       <= '0;
    end else begin
      v1        <= valid;
      l1        <= valid && last;
      sum_valid <= v1;
      sum_last  <= l1;
      sum       <= sum_d;
    end
  end

endmodule

// File: rtl/vecmac_stream.sv
// vecmac_stream: streaming int8 dot product, LANES elements per beat.
// Define VECMAC_SAT_EN for a saturating accumulator with an ovf output.
module vecmac_stream
  import vecmac_pkg::*;
#(
  parameter int LANES = 8,
  parameter int ACC_W = 32,
  parameter int LEN_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [LEN_W-1:0]     cfg_len,
  input  logic                 cfg_signed,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [8*LANES-1:0]   in_a,
  input  logic [8*LANES-1:0]   in_b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACC_W-1:0]     out_sum,
  output logic                 busy
`ifdef VECMAC_SAT_EN
  ,
  output logic                 ovf
`endif
);

  localparam int TW = tree_w(LANES);
  localparam int LG = $clog2(LANES);

  if (!lanes_legal(LANES) || !acc_legal(ACC_W)) begin : g_bad_param
    $error("vecmac_stream: illegal LANES or ACC_W");
  end

  state_t               state;
  logic [LEN_W:0]       beats_left;
  logic [LEN_W-1:0]     rem_q;
  logic                 sgn_q;
  logic                 zero_q;
  logic                 accept;
  logic                 xfer;
  logic                 last_beat;
  logic [LANES-1:0]     mask;
  logic                 t_valid;
  logic                 t_last;
  logic signed [TW-1:0] t_sum;
  logic [ACC_W-1:0]     acc;
  logic [ACC_W:0]       acc_nx;

  assign accept    = state == S_IDLE && start;
  assign xfer      = state == S_RUN && in_valid;
  assign last_beat = beats_left == (LEN_W+1)'(1);
  assign in_ready  = state == S_RUN;
  assign out_valid = state == S_DONE;
  assign busy      = state != S_IDLE;
  assign out_sum   = acc;

  // Only the final beat of a ragged vector has lanes switched off.
  always_comb begin
    mask = '1;
    if (last_beat && rem_q != '0)
      for (int i = 0; i < LANES; i++)
        if (LEN_W'(i) >= rem_q) mask[i] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      beats_left <= '0;
      rem_q      <= '0;
      sgn_q      <= 1'b0;
      zero_q     <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: if (start) begin
          beats_left <= ({1'b0, cfg_len} + (LEN_W+1)'(LANES-1)) >> LG;
          rem_q      <= cfg_len & LEN_W'(LANES-1);
          sgn_q      <= cfg_signed;
          zero_q     <= cfg_len == '0;
          state      <= (cfg_len == '0) ? S_DRAIN : S_RUN;
        end
        S_RUN: if (in_valid) begin
          beats_left <= beats_left - 1'b1;
          if (last_beat) state <= S_DRAIN;
        end
        S_DRAIN: if (zero_q || (t_valid && t_last)) state <= S_DONE;
        S_DONE:  if (out_ready) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  vecmac_lane_tree #(.LANES(LANES)) u_tree (
    .clk       (clk),
    .rst_n     (rst_n),
    .valid     (xfer),
    .last      (last_beat),
    .sgn       (sgn_q),
    .mask      (mask),
    .a         (in_a),
    .b         (in_b),
    .sum_valid (t_valid),
    .sum_last  (t_last),
    .sum       (t_sum)
  );

  assign acc_nx = {acc[ACC_W-1], acc} + (ACC_W+1)'(t_sum);

`ifdef VECMAC_SAT_EN
  localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  // Once clamped the accumulator is frozen until the next start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
      ovf <= 1'b0;
    end else if (accept) begin
      acc <= '0;
      ovf <= 1'b0;
    end else if (t_valid && !ovf) begin
      if (acc_nx[ACC_W] != acc_nx[ACC_W-1]) begin
        acc <= acc_nx[ACC_W] ? ACC_MIN : ACC_MAX;
        ovf <= 1'b1;
      end else begin
        acc <= acc_nx[ACC_W-1:0];
      end
    end
  end
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      acc <= '0;
    else if (accept)
      acc <= '0;
    else if (t_valid)
      acc <= acc_nx[ACC_W-1:0];
  end
`endif

endmodule

// File: tb/tb_vecmac_stream.sv
// tb_vecmac_stream: randomized and directed runs on a LANES=8/ACC_W=32 and a
// LANES=4/ACC_W=24 instance, checked against an element-level dot-product model.
module tb_vecmac_stream;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sel;
  logic        start;
  logic [15:0] cfg_len;
  logic        cfg_signed;
  logic        in_valid;
  logic [63:0] in_a;
  logic [63:0] in_b;
  logic        out_ready;

  logic        rdy0, rdy1, ov0, ov1, busy0, busy1;
  logic [31:0] sum0;
  logic [23:0] sum1;
  logic        rdy_m, ov_m, busy_m;
  logic [31:0] sum_m;
`ifdef VECMAC_SAT_EN
  logic        ovf0, ovf1, ovf_m;
  assign ovf_m = sel ? ovf1 : ovf0;
`endif

  assign rdy_m  = sel ? rdy1 : rdy0;
  assign ov_m   = sel ? ov1 : ov0;
  assign busy_m = sel ? busy1 : busy0;
  assign sum_m  = sel ? {8'd0, sum1} : sum0;

  int checks = 0;
  int errors = 0;

  logic [7:0] ea [4096];
  logic [7:0] eb [4096];

  always #5 clk = ~clk;

  vecmac_stream #(.LANES(8), .ACC_W(32), .LEN_W(16)) u_big (
    .clk(clk), .rst_n(rst_n), .start(start && !sel), .cfg_len(cfg_len),
    .cfg_signed(cfg_signed), .in_valid(in_valid), .in_ready(rdy0),
    .in_a(in_a), .in_b(in_b), .out_valid(ov0), .out_ready(out_ready),
    .out_sum(sum0), .busy(busy0)
`ifdef VECMAC_SAT_EN
    , .ovf(ovf0)
`endif
  );

  vecmac_stream #(.LANES(4), .ACC_W(24), .LEN_W(16)) u_small (
    .clk(clk), .rst_n(rst_n), .start(start && sel), .cfg_len(cfg_len),
    .cfg_signed(cfg_signed), .in_valid(in_valid), .in_ready(rdy1),
    .in_a(in_a[31:0]), .in_b(in_b[31:0]), .out_valid(ov1), .out_ready(out_ready),
    .out_sum(sum1), .busy(busy1)
`ifdef VECMAC_SAT_EN
    , .ovf(ovf1)
`endif
  );

  // Dot product over the first len elements, accumulated beat by beat.
  function automatic logic [31:0] golden(input int len, input bit sgn,
                                         input int lanes, input int w,
                                         output bit sat);
    longint acc;
    longint bsum;
    int     nb, k, pa, pb;
`ifdef VECMAC_SAT_EN
    longint hi, lo;
    hi = (longint'(1) << (w - 1)) - 1;
    lo = -hi - 1;
`endif
    acc = 0;
    sat = 1'b0;
    nb  = (len + lanes - 1) / lanes;
    for (int bt = 0; bt < nb; bt++) begin
      bsum = 0;
      for (int i = 0; i < lanes; i++) begin
        k = bt * lanes + i;
        if (k < len) begin
          pa = sgn ? int'($signed(ea[k])) : int'(ea[k]);
          pb = sgn ? int'($signed(eb[k])) : int'(eb[k]);
          bsum += longint'(pa * pb);
        end
      end
`ifdef VECMAC_SAT_EN
      if (!sat) begin
        acc += bsum;
        if (acc > hi) begin acc = hi; sat = 1'b1; end
        else if (acc < lo) begin acc = lo; sat = 1'b1; end
      end
`else
      acc += bsum;
`endif
    end
    return 32'(acc & ((longint'(1) << w) - 1));
  endfunction

  task automatic run_vec(input int len, input bit sgn, input bit cmode,
                         input logic [7:0] ca, input logic [7:0] cb,
                         input int gap_pct, input int hold,
                         input bit use_fixed, input logic [31:0] fixed,
                         input bit fixed_ovf, input string name);
    int L, w, nb, budget, lat;
    logic [31:0] exp, held;
    bit sat;
    bit timed_out;
    L = sel ? 4 : 8;
    w = sel ? 24 : 32;
    nb = (len + L - 1) / L;
    timed_out = 1'b0;
    for (int k = 0; k < nb * L; k++) begin
      ea[k] = cmode ? ca : 8'($urandom);
      eb[k] = cmode ? cb : 8'($urandom);
    end
    exp = golden(len, sgn, L, w, sat);
    if (use_fixed) exp = fixed;
    start = 1'b1; cfg_len = 16'(len); cfg_signed = sgn;
    @(posedge clk); #1;
    start = 1'b0;
    for (int bt = 0; bt < nb && !timed_out; bt++) begin
      while (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
        in_valid = 1'b0;
        @(posedge clk); #1;
      end
      in_valid = 1'b1;
      in_a = {$urandom, $urandom};
      in_b = {$urandom, $urandom};
      for (int i = 0; i < L; i++) begin
        in_a[8*i +: 8] = ea[bt*L + i];
        in_b[8*i +: 8] = eb[bt*L + i];
      end
      budget = 0;
      while (!rdy_m && budget < 20) begin
        @(posedge clk); #1;
        budget++;
      end
      if (!rdy_m) timed_out = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    checks++;
    if (timed_out) begin
      errors++;
      $display("FAIL %s in_ready timeout got 0 want 1", name);
    end
    lat = 0;
    while (!ov_m && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    checks++;
    if (lat !== (len == 0 ? 1 : 2)) begin
      errors++;
      $display("FAIL %s latency got %0d want %0d", name, lat, (len == 0 ? 1 : 2));
    end
    checks++;
    if (sum_m !== exp) begin
      errors++;
      $display("FAIL %s out_sum got %0h want %0h sat %0b", name, sum_m, exp, sat);
    end
`ifdef VECMAC_SAT_EN
    checks++;
    if (ovf_m !== (use_fixed ? fixed_ovf : sat)) begin
      errors++;
      $display("FAIL %s ovf got %0b want %0b", name, ovf_m, (use_fixed ? fixed_ovf : sat));
    end
`else
    if (fixed_ovf) $display("note %s expects no ovf port", name);
`endif
    held = sum_m;
    for (int h = 0; h < hold; h++) begin
      out_ready = 1'b0;
      start = 1'b1; cfg_len = 16'd3;
      @(posedge clk); #1;
      checks++;
      if (ov_m !== 1'b1 || sum_m !== held) begin
        errors++;
        $display("FAIL %s hold got valid %0b sum %0h want 1 %0h", name, ov_m, sum_m, held);
      end
    end
    start = 1'b0;
    out_ready = 1'b1;
    start = (hold > 0);
    @(posedge clk); #1;
    out_ready = 1'b0;
    start = 1'b0;
    checks++;
    if (ov_m !== 1'b0 || busy_m !== 1'b0) begin
      errors++;
      $display("FAIL %s handshake got valid %0b busy %0b want 0 0", name, ov_m, busy_m);
    end
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({rdy0, ov0, busy0, sum0, rdy1, ov1, busy1, sum1} !== '0) begin
      errors++;
      $display("FAIL reset outputs got %0h want 0",
               {rdy0, ov0, busy0, sum0, rdy1, ov1, busy1, sum1});
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({rdy0, ov0, busy0, rdy1, ov1, busy1} !== '0) begin
      errors++;
      $display("FAIL post_reset idle got %0h want 0", {rdy0, ov0, busy0, rdy1, ov1, busy1});
    end
  endtask

  task automatic test_unsigned_full();
    sel = 1'b0;
    run_vec(16, 1'b0, 1'b1, 8'd255, 8'd255, 0, 0, 1'b1, 32'd1040400, 1'b0, "unsigned_full");
  endtask

  task automatic test_signed_masked();
    sel = 1'b0;
    run_vec(10, 1'b1, 1'b1, 8'h80, 8'd127, 0, 0, 1'b1, 32'hFFFD_8500, 1'b0, "signed_masked");
  endtask

  task automatic test_zero_len();
    int  lat;
    bit  seen_ready;
    sel = 1'b0;
    in_valid = 1'b1;
    in_a = {$urandom, $urandom};
    in_b = {$urandom, $urandom};
    start = 1'b1; cfg_len = 16'd0; cfg_signed = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0;
    seen_ready = rdy_m;
    while (!ov_m && lat < 20) begin
      @(posedge clk); #1;
      seen_ready |= rdy_m;
      lat++;
    end
    checks++;
    if (lat !== 1) begin
      errors++;
      $display("FAIL zero_len latency got %0d want 1", lat);
    end
    checks++;
    if (seen_ready !== 1'b0 || sum_m !== 32'd0) begin
      errors++;
      $display("FAIL zero_len ready %0b sum %0h want 0 0", seen_ready, sum_m);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_random_gaps();
    sel = 1'b0;
    for (int r = 0; r < 6; r++)
      run_vec($urandom_range(40, 1), 1'($urandom), 1'b0, 8'd0, 8'd0,
              30, 5, 1'b0, 32'd0, 1'b0, "random_gaps");
  endtask

  task automatic test_back_to_back();
    sel = 1'b1;
    for (int r = 0; r < 4; r++)
      run_vec($urandom_range(23, 1), 1'($urandom), 1'b0, 8'd0, 8'd0,
              0, 0, 1'b0, 32'd0, 1'b0, "back_to_back");
    sel = 1'b0;
  endtask

  task automatic test_reset_mid_run();
    sel = 1'b0;
    start = 1'b1; cfg_len = 16'd64; cfg_signed = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    in_valid = 1'b1;
    in_a = {8{8'd1}};
    in_b = {8{8'd1}};
    repeat (3) @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({rdy0, ov0, busy0, sum0} !== '0) begin
      errors++;
      $display("FAIL reset_mid_run got %0h want 0", {rdy0, ov0, busy0, sum0});
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    sel = 1'b1;
    run_vec(4, 1'b0, 1'b1, 8'd1, 8'd1, 0, 0, 1'b1, 32'd4, 1'b0, "after_reset");
    sel = 1'b0;
  endtask

  task automatic test_saturate();
    sel = 1'b1;
`ifdef VECMAC_SAT_EN
    run_vec(1024, 1'b1, 1'b1, 8'h80, 8'h80, 0, 0, 1'b1, 32'h007F_FFFF, 1'b1, "saturate");
`else
    run_vec(1024, 1'b1, 1'b1, 8'h80, 8'h80, 0, 0, 1'b1, 32'd0, 1'b0, "wrap");
`endif
    sel = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; sel = 1'b0; start = 1'b0; cfg_len = '0; cfg_signed = 1'b0;
    in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    test_reset();
    test_unsigned_full();
    test_signed_masked();
    test_zero_len();
    test_random_gaps();
    test_back_to_back();
    test_reset_mid_run();
    test_saturate();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
